// File: rtl/logic_arb_pkg.sv
// Shared definitions for the shared logic-unit arbiter: op encodings and response FSM states.
package logic_arb_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the datapath clients (master) and the shared logic unit (slave).
interface logic_unit_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
) ();

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping, wins.
module rr_arbiter #(
  parameter  int unsigned N   = 4,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] index,
  output logic           any
);

  int unsigned pos;

  always_comb begin
    gnt   = '0;
    index = '0;
    any   = 1'b0;
    pos   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = (32'(last) + k) % N;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        index    = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// One bitwise logic unit shared by NUM_REQ clients; round-robin accept, registered tagged response.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned WIDTH   = 8,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input logic                 clk,
  input logic                 rst_n,
  logic_unit_arbiter_if.slave bus
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       last_grant_q, last_grant_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                 run_q, run_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [IDW-1:0]       win_idx;
  logic                 any_req;
  logic                 slot_open;
  logic [NUM_REQ-1:0]   req_ready_c;
  logic [1:0]           op_sel;
  logic [WIDTH-1:0]     a_sel, b_sel, result;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (bus.req_valid),
    .last  (last_grant_q),
    .gnt   (gnt),
    .index (win_idx),
    .any   (any_req)
  );

  // Operand mux keyed on the one-hot grant, then the bitwise op.
  always_comb begin
    op_sel = OP_AND;
    a_sel  = '0;
    b_sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        op_sel = bus.req_op[2*i +: 2];
        a_sel  = bus.req_a[WIDTH*i +: WIDTH];
        b_sel  = bus.req_b[WIDTH*i +: WIDTH];
      end
    end
    result = a_sel & b_sel;
    unique case (op_sel)
      OP_AND:  result = a_sel & b_sel;
      OP_OR:   result = a_sel | b_sel;
      OP_XOR:  result = a_sel ^ b_sel;
      OP_NAND: result = ~(a_sel & b_sel);
      default: result = a_sel & b_sel;
    endcase
  end

  // run_q keeps accepts off until the first clock after reset release.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    run_d        = 1'b1;
    req_ready_c  = '0;
    slot_open    = run_q && ((state_q == ST_IDLE) || bus.rsp_ready);

    if (slot_open && any_req) begin
      req_ready_c  = gnt;
      state_d      = ST_RESP;
      last_grant_d = win_idx;
      rsp_id_d     = win_idx;
      rsp_data_d   = result;
    end else if ((state_q == ST_RESP) && bus.rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      run_q        <= run_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomized and directed bench for logic_unit_arbiter against a transaction-level reference model.
module tb_logic_unit_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pointer to last served client plus the response currently held.
  int         m_last;
  bit         m_held;
  int         m_id;
  logic [W-1:0] m_data;
  int         last_win;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    m_held = 1'b0;
    m_id   = 0;
    m_data = '0;
  endtask

  // One clock of traffic: drive, check grant, advance model, check response.
  task automatic step(input logic [N-1:0] v, input logic [2*N-1:0] op,
                      input logic [W*N-1:0] a, input logic [W*N-1:0] b, input logic rr);
    logic [N-1:0] exp_ready;
    int win;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = rr;
    #1;
    exp_ready = '0;
    win = -1;
    if (!m_held || rr) begin
      for (int k = 1; k <= int'(N); k++) begin
        int i;
        i = (m_last + k) % N;
        if (win < 0 && v[i]) win = i;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    if (win >= 0) begin
      m_held = 1'b1;
      m_id   = win;
      m_data = ref_op(op[2*win +: 2], a[W*win +: W], b[W*win +: W]);
      m_last = win;
    end else if (m_held && rr) begin
      m_held = 1'b0;
    end
    last_win = win;
    @(posedge clk);
    #1;
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_held));
    check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
    check("rsp_data", 32'(bus.rsp_data), 32'(m_data));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
  endtask

  logic [2*N-1:0] op_v;
  logic [W*N-1:0] a_v, b_v;
  logic [N-1:0]   pv;
  logic [1:0]     dir_ops [4];
  logic [7:0]     dir_exp [4];

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    model_reset();
    last_win = -1;

    // Reset with all clients asserting, first grant goes to client 0.
    do_reset();
    op_v = 2*N'($urandom); a_v = W*N'($urandom); b_v = W*N'($urandom);
    step('1, op_v, a_v, b_v, 1'b1);
    check("first_grant", 32'(bus.rsp_id), 32'd0);

    // Directed single ops on client 2.
    dir_ops = '{2'b00, 2'b01, 2'b10, 2'b11};
    dir_exp = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
    for (int t = 0; t < 4; t++) begin
      op_v = '0; a_v = '0; b_v = '0;
      op_v[2*2 +: 2] = dir_ops[t];
      a_v[W*2 +: W]  = 8'hF0;
      b_v[W*2 +: W]  = 8'h3C;
      step(4'b0100, op_v, a_v, b_v, 1'b1);
      check("single_id", 32'(bus.rsp_id), 32'd2);
      check("single_data", 32'(bus.rsp_data), 32'(dir_exp[t]));
    end

    // Round robin from reset with everyone valid.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      op_v = 2*N'($urandom); a_v = W*N'($urandom); b_v = W*N'($urandom);
      step('1, op_v, a_v, b_v, 1'b1);
      check("rr_seq", 32'(bus.rsp_id), 32'(k % N));
    end

    // Backpressure holds everything, release admits the next client at once.
    for (int k = 0; k < 5; k++) step('1, op_v, a_v, b_v, 1'b0);
    check("bp_hold_id", 32'(bus.rsp_id), 32'd1);
    step('1, op_v, a_v, b_v, 1'b1);
    check("bp_release_id", 32'(bus.rsp_id), 32'd2);

    // Skip and wrap with only clients 1 and 3 active after serving 3.
    do_reset();
    step(4'b1000, op_v, a_v, b_v, 1'b1);
    step(4'b1010, op_v, a_v, b_v, 1'b1);
    check("wrap_1a", 32'(bus.rsp_id), 32'd1);
    step(4'b1010, op_v, a_v, b_v, 1'b1);
    check("wrap_3", 32'(bus.rsp_id), 32'd3);
    step(4'b1010, op_v, a_v, b_v, 1'b1);
    check("wrap_1b", 32'(bus.rsp_id), 32'd1);

    // Asynchronous reset while a response is stalled.
    step(4'b0001, op_v, a_v, b_v, 1'b1);
    step(4'b0000, op_v, a_v, b_v, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    step('1, op_v, a_v, b_v, 1'b1);
    check("post_async_grant", 32'(bus.rsp_id), 32'd0);

    // Randomized traffic; a client keeps its payload until granted or it drops out.
    pv = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!pv[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            pv[i] = 1'b1;
            op_v[2*i +: 2] = 2'($urandom);
            a_v[W*i +: W]  = W'($urandom);
            b_v[W*i +: W]  = W'($urandom);
          end
        end else if ($urandom_range(15, 0) == 0) begin
          pv[i] = 1'b0;
        end
      end
      step(pv, op_v, a_v, b_v, ($urandom_range(3, 0) != 0));
      if (last_win >= 0) pv[last_win] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one bitwise logic unit (AND/OR/XOR/NAND over WIDTH bits) among NUM_REQ requesters. A round-robin arbiter picks one pending request per accept slot, registers the result, and returns it on a single response channel tagged with the requester index. It sits between the lab's datapath clients and the shared gate-level evaluation resource, so no client needs its own logic unit.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- IDW, $clog2(NUM_REQ), requester-index width (derived, not overridable)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_op  in  2*NUM_REQ  op for requester i at [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 NAND
- req_a  in  WIDTH*NUM_REQ  operand A, requester i at [WIDTH*i +: WIDTH]
- req_b  in  WIDTH*NUM_REQ  operand B, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of requester whose result is on rsp_data
- rsp_data  out  WIDTH  registered result

## Operation
- States: IDLE (no response held), RESP (response held, rsp_valid=1).
- Accept slot open when state==IDLE, or state==RESP && rsp_ready.
- When slot open and any req_valid: winner = first i with req_valid[i], scanning from (last_grant+1) mod NUM_REQ upward with wrap. req_ready[winner]=1 combinationally; all other bits 0.
- On accept: rsp_data <= op(req_a[w], req_b[w]); rsp_id <= w; last_grant <= w; state <= RESP.
- RESP && rsp_ready && no req_valid: state <= IDLE; rsp_data/rsp_id hold last values.
- RESP && !rsp_ready: nothing accepted, all req_ready=0, rsp_* stable.
- Requester must hold req_valid and payload stable until its req_ready; dropping valid before ready is permitted and simply removes it from arbitration.
- last_grant updates only on accept; requests not accepted do not move the pointer.
- NAND = ~(a & b); all ops bitwise, no carries, result exactly WIDTH bits.

## Timing
- Reset (async assert, sync-safe deassert via flops): state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, last_grant=NUM_REQ-1 (requester 0 first), req_ready=0 while rst_n low.
- Latency: accept in cycle t -> rsp_valid=1 with result in cycle t+1.
- Throughput: one result per cycle when rsp_ready held high and requests pending.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0,...; any valid requester is granted within NUM_REQ accepts.
- req_ready depends combinationally on req_valid, rsp_ready, state, last_grant; no combinational path from req_a/req_b/req_op to any output.
- Reset mid-response: held response discarded, rsp_valid drops immediately on rst_n low.

## Structure
- Package logic_arb_pkg: op encoding localparams (OP_AND, OP_OR, OP_XOR, OP_NAND), state enum (ST_IDLE, ST_RESP).
- Sub-module rr_arbiter (parameter N): inputs req[N], last[IDW]; outputs one-hot gnt[N], index[IDW], any. Pure combinational, reused elsewhere.
- Top holds FSM, last_grant, operand mux, op evaluation, response register.

## Test plan
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=0; release -> first grant to requester 0.
- Single op: req 2 valid, op=00, a=8'hF0, b=8'h3C -> req_ready[2] one cycle, next cycle rsp_valid=1, rsp_id=2, rsp_data=8'h30; repeat with ops 01/10/11 -> 8'hFC, 8'hCC, 8'hCF.
- Round-robin: all four valid, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles.
- Backpressure: rsp_ready=0 for 5 cycles with pending requests -> rsp_* unchanged, req_ready all 0; rsp_ready=1 -> next winner accepted that same cycle.
- Skip/wrap: last_grant=3, only req 1 and 3 valid -> req 1 granted, then req 3, then req 1.
- Async reset during RESP with rsp_ready=0 -> rsp_valid falls without clock edge; after release, last_grant restarts at requester 0.
